// File: rtl/keystream_xor.sv
// rtl/keystream_xor.sv - folds PRNG triplets into key bytes and XORs them onto a pixel stream
module keystream_xor #(
    parameter int KEY_DEPTH = 16,
    parameter int PRECISION = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 prng_tvalid,
    input  logic                 prng_valid,
    input  logic [PRECISION-1:0] prng_x1,
    input  logic [PRECISION-1:0] prng_x2,
    input  logic [PRECISION-1:0] prng_x3,
    input  logic                 s_tvalid,
    input  logic [7:0]           s_tdata,
    input  logic                 s_tlast,
    output logic                 s_tready,
    output logic                 m_tvalid,
    output logic [7:0]           m_tdata,
    output logic                 m_tlast,
    input  logic                 m_tready,
    output logic                 overflow,
    output logic                 done
);

    localparam int PTR_W = $clog2(KEY_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(KEY_DEPTH);

    typedef enum logic [1:0] {IDLE, SEED, RUN} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               m_tvalid_q, m_tvalid_d;
    logic [7:0]         m_tdata_q, m_tdata_d;
    logic               m_tlast_q, m_tlast_d;
    logic               overflow_q, overflow_d;
    logic [7:0]         mem_q [KEY_DEPTH];
    logic [7:0]         mem_d [KEY_DEPTH];

    logic               s_ready_c, accept, done_c, capture, fits, push;
    logic [PTR_W-1:0]   wp1, wp2;

    // Only the low half-word of each float feeds the key fold.
    logic unused_hi_bits;
    assign unused_hi_bits = ^{prng_x1[PRECISION-1:16], prng_x2[PRECISION-1:16], prng_x3[PRECISION-1:16]};

    function automatic logic [7:0] fold(input logic [15:0] w);
        return w[7:0] ^ w[15:8];
    endfunction

    always_comb begin
        s_ready_c = (state_q == RUN) && (count_q != '0) && (!m_tvalid_q || m_tready);
        accept    = s_ready_c && s_tvalid;
        done_c    = m_tvalid_q && m_tready && m_tlast_q;
        capture   = (state_q != IDLE) && prng_valid;
        // Free space is judged before this cycle's pop so a full triplet never splits.
        fits      = (DEPTH_C - count_q) >= CNT_W'(3);
        push      = capture && fits;
        wp1       = wr_ptr_q + PTR_W'(1);
        wp2       = wr_ptr_q + PTR_W'(2);

        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        m_tvalid_d = m_tvalid_q;
        m_tdata_d  = m_tdata_q;
        m_tlast_d  = m_tlast_q;
        overflow_d = overflow_q;
        mem_d      = mem_q;

        case (state_q)
            IDLE:    if (start) state_d = SEED;
            SEED:    state_d = RUN;
            RUN:     if (done_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (push) begin
            mem_d[wr_ptr_q] = fold(prng_x1[15:0]);
            mem_d[wp1]      = fold(prng_x2[15:0]);
            mem_d[wp2]      = fold(prng_x3[15:0]);
            wr_ptr_d        = wr_ptr_q + PTR_W'(3);
        end else if (capture) begin
            overflow_d = 1'b1;
        end

        if (accept) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + (push ? CNT_W'(3) : '0) - (accept ? CNT_W'(1) : '0);

        if (accept) begin
            m_tdata_d  = s_tdata ^ mem_q[rd_ptr_q];
            m_tlast_d  = s_tlast;
            m_tvalid_d = 1'b1;
        end else if (m_tready) begin
            m_tvalid_d = 1'b0;
        end

        if (state_q == IDLE && start) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            m_tvalid_d = 1'b0;
            m_tdata_d  = '0;
            m_tlast_d  = 1'b0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tlast_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q  <= m_tdata_d;
            m_tlast_q  <= m_tlast_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign prng_tvalid = (state_q == SEED) && !reset;
    assign s_tready    = s_ready_c;
    assign m_tvalid    = m_tvalid_q;
    assign m_tdata     = m_tdata_q;
    assign m_tlast     = m_tlast_q;
    assign overflow    = overflow_q;
    assign done        = done_c;

endmodule

// File: tb/tb_keystream_xor.sv
// tb/tb_keystream_xor.sv - directed and random checks of keystream_xor against a queue model
module tb_keystream_xor;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset, start, prng_valid, s_tvalid, s_tlast, m_tready;
    logic [31:0] prng_x1, prng_x2, prng_x3;
    logic [7:0]  s_tdata;
    logic        prng_tvalid, s_tready, m_tvalid, m_tlast, overflow, done;
    logic [7:0]  m_tdata;

    keystream_xor #(.KEY_DEPTH(DEPTH), .PRECISION(32)) dut (
        .clk(clk), .reset(reset), .start(start), .prng_tvalid(prng_tvalid),
        .prng_valid(prng_valid), .prng_x1(prng_x1), .prng_x2(prng_x2), .prng_x3(prng_x3),
        .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready),
        .overflow(overflow), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: session phase (0 idle, 1 seeding, 2 running) and the key bytes as a queue
    int         mode = 0;
    logic [7:0] keyq[$];
    logic       mv = 1'b0, ml = 1'b0, ovf = 1'b0, macc = 1'b0;
    logic [7:0] md = 8'h00;
    logic [7:0] got[$];
    int         ndone = 0, dut_acc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] keyof(input logic [31:0] w);
        return w[7:0] ^ w[15:8];
    endfunction

    task automatic tick();
        logic       rdy, dn;
        int         free;
        logic [7:0] head;
        #1;
        rdy = (mode == 2) && (keyq.size() != 0) && (!mv || m_tready);
        dn  = mv && m_tready && ml;
        chk("prng_tvalid", 32'(prng_tvalid), 32'(mode == 1 && !reset));
        chk("s_tready", 32'(s_tready), 32'(rdy));
        chk("m_tvalid", 32'(m_tvalid), 32'(mv));
        chk("m_tdata", 32'(m_tdata), 32'(md));
        chk("m_tlast", 32'(m_tlast), 32'(ml));
        chk("overflow", 32'(overflow), 32'(ovf));
        chk("done", 32'(done), 32'(dn));
        if (m_tvalid && m_tready) got.push_back(m_tdata);
        if (done) ndone++;
        if (s_tready && s_tvalid) dut_acc++;
        macc = 1'b0;
        if (reset) begin
            mode = 0; keyq.delete(); mv = 0; md = 0; ml = 0; ovf = 0;
        end else if (mode == 0) begin
            if (start) begin
                mode = 1; keyq.delete(); mv = 0; md = 0; ml = 0; ovf = 0;
            end else if (m_tready) begin
                mv = 0;
            end
        end else begin
            free = DEPTH - keyq.size();
            if (rdy && s_tvalid) begin
                head = keyq.pop_front();
                md = s_tdata ^ head; ml = s_tlast; mv = 1; macc = 1'b1;
            end else if (m_tready) begin
                mv = 0;
            end
            if (prng_valid) begin
                if (free >= 3) begin
                    keyq.push_back(keyof(prng_x1));
                    keyq.push_back(keyof(prng_x2));
                    keyq.push_back(keyof(prng_x3));
                end else begin
                    ovf = 1;
                end
            end
            if (mode == 1) mode = 2;
            else if (dn) mode = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_triplet();
        prng_x1 = $urandom; prng_x2 = $urandom; prng_x3 = $urandom;
    endtask

    task automatic begin_session();
        start = 1; tick(); start = 0;
    endtask

    task automatic push_triplets(input int n);
        for (int i = 0; i < n; i++) begin
            prng_valid = 1; rand_triplet(); tick();
        end
        prng_valid = 0;
    endtask

    // Sends a final pixel (topping up keys first) and drains so the session returns to idle
    task automatic finish_session();
        s_tvalid = 0; m_tready = 1;
        push_triplets(1);
        s_tvalid = 1; s_tlast = 1; s_tdata = 8'($urandom);
        for (int k = 0; k < 40; k++) begin
            tick();
            if (macc) break;
        end
        chk("finish_accept", 32'(macc), 32'd1);
        s_tvalid = 0; s_tlast = 0;
        repeat (3) tick();
    endtask

    initial begin
        reset = 1; start = 0; prng_valid = 0; s_tvalid = 0; s_tlast = 0; m_tready = 0;
        s_tdata = 0; prng_x1 = 0; prng_x2 = 0; prng_x3 = 0;
        @(posedge clk); #1;
        tick(); tick();
        reset = 0;
        tick(); tick();

        // Known-answer session
        begin_session();
        tick(); tick();
        prng_valid = 1; prng_x1 = 32'h3dcccccd; prng_x2 = 32'h3c23d70a; prng_x3 = 32'h0;
        tick();
        prng_valid = 0;
        got.delete(); ndone = 0; m_tready = 1; s_tvalid = 1;
        s_tdata = 8'h00; tick();
        s_tdata = 8'hFF; tick();
        s_tdata = 8'h5A; s_tlast = 1; tick();
        s_tvalid = 0; s_tlast = 0;
        repeat (3) tick();
        chk("kat_count", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            chk("kat_b0", 32'(got[0]), 32'h01);
            chk("kat_b1", 32'(got[1]), 32'h22);
            chk("kat_b2", 32'(got[2]), 32'h5A);
        end
        chk("kat_done", 32'(ndone), 32'd1);

        // Downstream stall of five cycles mid-stream
        begin_session();
        push_triplets(3);
        dut_acc = 0; s_tvalid = 1;
        for (int i = 0; i < 12; i++) begin
            s_tdata = 8'($urandom);
            m_tready = !(i >= 3 && i < 8);
            tick();
        end
        s_tvalid = 0; m_tready = 1; tick();
        chk("stall_acc", 32'(dut_acc), 32'd7);
        finish_session();

        // Six triplets into a 16-byte FIFO
        begin_session();
        push_triplets(6);
        tick();
        chk("ovf_set", 32'(overflow), 32'd1);
        dut_acc = 0; m_tready = 1; s_tvalid = 1;
        repeat (18) begin s_tdata = 8'($urandom); tick(); end
        s_tvalid = 0; tick();
        chk("ovf_keys", 32'(dut_acc), 32'd15);
        chk("ovf_hold", 32'(overflow), 32'd1);
        finish_session();
        chk("ovf_idle_hold", 32'(overflow), 32'd1);

        // Count 14 with a coincident pop: pre-read free space is only 2
        begin_session();
        chk("ovf_clear", 32'(overflow), 32'd0);
        push_triplets(5);
        m_tready = 1; s_tvalid = 1; s_tdata = 8'($urandom); tick();
        prng_valid = 1; rand_triplet(); tick();
        prng_valid = 0; s_tvalid = 0; tick();
        chk("c14_ovf", 32'(overflow), 32'd1);
        dut_acc = 0; s_tvalid = 1;
        repeat (16) begin s_tdata = 8'($urandom); tick(); end
        s_tvalid = 0; tick();
        chk("c14_keys", 32'(dut_acc), 32'd13);
        finish_session();

        // Reset mid-session with count 9 and an output beat pending
        begin_session();
        push_triplets(4);
        m_tready = 1; s_tvalid = 1;
        repeat (3) begin s_tdata = 8'($urandom); tick(); end
        s_tvalid = 0; m_tready = 0; tick();
        chk("pre_rst_mvalid", 32'(m_tvalid), 32'd1);
        reset = 1; tick(); reset = 0;
        chk("rst_mvalid", 32'(m_tvalid), 32'd0);
        chk("rst_mdata", 32'(m_tdata), 32'd0);
        m_tready = 1;
        push_triplets(1);
        tick();
        begin_session();
        tick(); tick();
        chk("rst_no_keys", 32'(s_tready), 32'd0);
        finish_session();

        // Randomized sessions
        for (int s = 0; s < 5; s++) begin
            begin_session();
            for (int i = 0; i < 120; i++) begin
                prng_valid = ($urandom_range(0, 99) < 15);
                rand_triplet();
                s_tvalid = 1'($urandom_range(0, 1));
                s_tdata  = 8'($urandom);
                m_tready = ($urandom_range(0, 99) < 70);
                tick();
            end
            prng_valid = 0;
            finish_session();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
